controlador_elevador: RTL and testbench
=======================================

CONTROLADOR_ELEVADOR -- requirements
Module: controlador_elevador

Interface
REQ-001 Parameter TRAVEL_CYCLES, default 8, clock cycles to travel one floor (>=2).
REQ-002 Parameter DOOR_CYCLES, default 16, clock cycles the door stays open (>=1).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  floor call present.
REQ-006 req_floor  input  2  requested floor, 0..3.
REQ-007 req_ready  output  1  controller accepts a call this cycle.
REQ-008 floor  output  2  current floor, registered.
REQ-009 motor_up  output  1  car moving up, registered.
REQ-010 motor_down  output  1  car moving down, registered.
REQ-011 door_open  output  1  door open, registered.
REQ-012 arrived  output  1  one-cycle pulse on reaching the target.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, MOVE_UP, MOVE_DOWN and DOOR; req_ready SHALL equal (state==IDLE), decoded from the state.
REQ-015 A call SHALL be accepted on the edge where req_valid && req_ready; req_floor SHALL be latched into an internal 2-bit target.
REQ-016 At acceptance, req_floor>floor SHALL go to MOVE_UP, req_floor<floor to MOVE_DOWN, and equality to DOOR with arrived pulsed in the first DOOR cycle.
REQ-017 In MOVE_*, a travel counter SHALL count TRAVEL_CYCLES cycles; at terminal count floor SHALL step by +1/-1 and the counter SHALL restart at 0.
REQ-018 When the stepped floor equals target, the FSM SHALL go to DOOR at that same edge; motor output drops and door_open and arrived rise together in the next cycle.
REQ-019 motor_up/motor_down SHALL be high exactly while in MOVE_UP/MOVE_DOWN, never both; door_open SHALL be high exactly while in DOOR.
REQ-020 DOOR SHALL last DOOR_CYCLES cycles, then return to IDLE.
REQ-021 floor SHALL never wrap: no step below 0 or above 3; this is guaranteed by construction because target stays in range.
REQ-022 Calls presented while not IDLE SHALL be ignored (no queueing); req_valid held across the return to IDLE SHALL be accepted in the first IDLE cycle.

Reset
REQ-023 On an edge with rst_n low: state=IDLE, floor=0, target=0, counters=0, motor_up=motor_down=door_open=arrived=0. Consequently busy=0 and req_ready=1 after that edge.
REQ-024 Reset in the middle of an operation SHALL abort the motion or door immediately; the floor position is forced to 0.

Configuration
REQ-025 With EMERG_STOP_EN defined, an input port emerg (1 bit) SHALL exist. While emerg=1: state, floor, travel counter and door counter freeze; motor_up=motor_down=0 from the next cycle; door_open holds its value; req_ready=0. Operation resumes exactly where it stopped when emerg returns to 0.
REQ-026 Without EMERG_STOP_EN, the emerg port SHALL NOT exist and the behaviour is that of REQ-014..022.

Structure
REQ-027 A shared package SHALL hold the state encoding (2 bits: IDLE=0, MOVE_UP=1, MOVE_DOWN=2, DOOR=3) and the floor constants FLOOR_MIN=0 and FLOOR_MAX=3.
REQ-028 The floor-vs-target decision SHALL use one instance of the team's 2-bit magnitude comparator sub-module, comparador. Its G output means x>y and its L output means x<y; x = target (or req_floor in IDLE) and y = floor.

Verification (TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-029 Reset: rst_n=0 for 2 cycles -> floor=0, all motor/door/arrived=0, busy=0, req_ready=1.
REQ-030 Floor 0, call floor 3 -> motor_up for 12 cycles, floor 1/2/3 after 4/8/12 cycles, then arrived=1 for one cycle, door_open for 3 cycles, then IDLE.
REQ-031 Floor 3, call floor 1 -> motor_down for 8 cycles, floor 2 then 1, arrived, door 3 cycles. A call for floor 0 during the motion -> ignored, req_ready=0.
REQ-032 Floor 2, call floor 2 -> no motor, door_open and arrived in the cycle after acceptance, IDLE after 3 cycles.
REQ-033 rst_n=0 in cycle 6 of a 0->3 trip -> next cycle floor=0, motor_up=0, req_ready=1.
REQ-034 EMERG_STOP_EN defined: emerg=1 for 5 cycles in the middle of MOVE_UP -> floor and counter frozen, motor_up=0; on release the remaining travel cycles are completed without loss.

Source files
------------

// File: rtl/controlador_elevador_pkg.sv
// Shared definitions for the elevator controller.
//   estado_t  : 2-bit FSM state encoding (IDLE=0, MOVE_UP=1, MOVE_DOWN=2, DOOR=3)
//   FLOOR_MIN : lowest floor served
//   FLOOR_MAX : highest floor served
package controlador_elevador_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StMoveUp   = 2'd1,
        StMoveDown = 2'd2,
        StDoor     = 2'd3
    } estado_t;

    localparam logic [1:0] FLOOR_MIN = 2'd0;
    localparam logic [1:0] FLOOR_MAX = 2'd3;

endpackage

// File: rtl/controlador_elevador_comparador.sv
// 2-bit unsigned magnitude comparator.
//   x_i, y_i : operands
//   g_o      : x_i > y_i
//   l_o      : x_i < y_i
// Equality is the case where neither output is set.
module comparador (
    input  logic [1:0] x_i,
    input  logic [1:0] y_i,
    output logic       g_o,
    output logic       l_o
);

    assign g_o = (x_i > y_i);
    assign l_o = (x_i < y_i);

endmodule

// File: rtl/controlador_elevador.sv
// Four-floor elevator controller.
// Accepts one call at a time while idle, moves the car one floor per TRAVEL_CYCLES
// clocks, opens the door for DOOR_CYCLES clocks on arrival, then returns to idle.
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   req_valid  : floor call present
//   req_floor  : requested floor 0..3
//   emerg      : emergency freeze (only when EMERG_STOP_EN is defined)
//   req_ready  : call accepted this cycle when req_valid is high
//   floor      : current floor (registered)
//   motor_up   : car moving up (registered)
//   motor_down : car moving down (registered)
//   door_open  : door open (registered)
//   arrived    : one-cycle pulse on reaching the target
//   busy       : any state other than idle
// Optional feature macro: EMERG_STOP_EN adds the emerg input.
module controlador_elevador
    import controlador_elevador_pkg::*;
#(
    parameter int unsigned TRAVEL_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [1:0] req_floor,
`ifdef EMERG_STOP_EN
    input  logic       emerg,
`endif
    output logic       req_ready,
    output logic [1:0] floor,
    output logic       motor_up,
    output logic       motor_down,
    output logic       door_open,
    output logic       arrived,
    output logic       busy
);

    localparam int unsigned TW = $clog2(TRAVEL_CYCLES);
    localparam int unsigned DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

    estado_t       state_q, state_d;
    logic [1:0]    floor_q, floor_d;
    logic [1:0]    target_q, target_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          motor_up_q, motor_up_d;
    logic          motor_down_q, motor_down_d;
    logic          door_open_q, door_open_d;
    logic          arrived_q, arrived_d;

    logic          emerg_act;
    logic [1:0]    floor_up, floor_dn;
    logic [1:0]    cmp_x, cmp_y;
    logic          cmp_g, cmp_l;

`ifdef EMERG_STOP_EN
    assign emerg_act = emerg;
`else
    assign emerg_act = 1'b0;
`endif

    // Saturating steps; the target range already keeps the car in bounds.
    assign floor_up = (floor_q == FLOOR_MAX) ? floor_q : floor_q + 2'd1;
    assign floor_dn = (floor_q == FLOOR_MIN) ? floor_q : floor_q - 2'd1;

    // In idle the comparator decides the direction of a new call; while moving it
    // compares the target against the floor the car is about to step to, so arrival
    // is recognised on the same edge as the final step.
    always_comb begin
        cmp_x = target_q;
        cmp_y = floor_q;
        unique case (state_q)
            StIdle: begin
                cmp_x = req_floor;
                cmp_y = floor_q;
            end
            StMoveUp:   cmp_y = floor_up;
            StMoveDown: cmp_y = floor_dn;
            default:    cmp_y = floor_q;
        endcase
    end

    comparador u_comparador (
        .x_i (cmp_x),
        .y_i (cmp_y),
        .g_o (cmp_g),
        .l_o (cmp_l)
    );

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        target_d  = target_q;
        tcnt_d    = tcnt_q;
        dcnt_d    = dcnt_q;
        arrived_d = 1'b0;

        if (!emerg_act) begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        target_d = req_floor;
                        tcnt_d   = '0;
                        dcnt_d   = '0;
                        if (cmp_g) begin
                            state_d = StMoveUp;
                        end else if (cmp_l) begin
                            state_d = StMoveDown;
                        end else begin
                            state_d   = StDoor;
                            arrived_d = 1'b1;
                        end
                    end
                end
                StMoveUp, StMoveDown: begin
                    if (tcnt_q == TRAVEL_LAST) begin
                        tcnt_d  = '0;
                        floor_d = (state_q == StMoveUp) ? floor_up : floor_dn;
                        if (!cmp_g && !cmp_l) begin
                            state_d   = StDoor;
                            dcnt_d    = '0;
                            arrived_d = 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                StDoor: begin
                    if (dcnt_q == DOOR_LAST) begin
                        dcnt_d  = '0;
                        state_d = StIdle;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Motors drop during a freeze; the door simply follows the held state.
        motor_up_d   = (state_d == StMoveUp) && !emerg_act;
        motor_down_d = (state_d == StMoveDown) && !emerg_act;
        door_open_d  = (state_d == StDoor);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            floor_q      <= FLOOR_MIN;
            target_q     <= FLOOR_MIN;
            tcnt_q       <= '0;
            dcnt_q       <= '0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            door_open_q  <= 1'b0;
            arrived_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            floor_q      <= floor_d;
            target_q     <= target_d;
            tcnt_q       <= tcnt_d;
            dcnt_q       <= dcnt_d;
            motor_up_q   <= motor_up_d;
            motor_down_q <= motor_down_d;
            door_open_q  <= door_open_d;
            arrived_q    <= arrived_d;
        end
    end

    assign req_ready  = (state_q == StIdle) && !emerg_act;
    assign busy       = (state_q != StIdle);
    assign floor      = floor_q;
    assign motor_up   = motor_up_q;
    assign motor_down = motor_down_q;
    assign door_open  = door_open_q;
    assign arrived    = arrived_q;

endmodule

// File: tb/tb_controlador_elevador.sv
// Scoreboard bench for controlador_elevador (TRAVEL_CYCLES=4, DOOR_CYCLES=3).
// Expected per-cycle output vectors are pushed when a call is issued and popped
// on each falling edge.
module tb_controlador_elevador;

    localparam int T = 4;
    localparam int D = 3;

    typedef struct packed {
        logic [1:0] floor;
        logic       mu;
        logic       md;
        logic       door;
        logic       arr;
        logic       busy;
        logic       ready;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic [1:0] req_floor;
    logic       req_ready;
    logic [1:0] floor;
    logic       motor_up;
    logic       motor_down;
    logic       door_open;
    logic       arrived;
    logic       busy;
`ifdef EMERG_STOP_EN
    logic       emerg;
`endif

    int   n_tests;
    int   n_fail;
    obs_t exp_q[$];

    controlador_elevador #(
        .TRAVEL_CYCLES (T),
        .DOOR_CYCLES   (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_floor  (req_floor),
`ifdef EMERG_STOP_EN
        .emerg      (emerg),
`endif
        .req_ready  (req_ready),
        .floor      (floor),
        .motor_up   (motor_up),
        .motor_down (motor_down),
        .door_open  (door_open),
        .arrived    (arrived),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got={fl,up,dn,door,arr,busy,rdy}=%b required=%b", tag, got, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.floor = floor;
        o.mu    = motor_up;
        o.md    = motor_down;
        o.door  = door_open;
        o.arr   = arrived;
        o.busy  = busy;
        o.ready = req_ready;
        return o;
    endfunction

    // Expected outputs k cycles after a call from floor a to floor b was accepted.
    function automatic obs_t rec(input int a, input int b, input int k);
        obs_t r;
        int   d;
        int   m;
        r = '0;
        d = (b > a) ? b - a : a - b;
        m = d * T;
        if (k < m) begin
            r.floor = (b > a) ? 2'(a + k / T) : 2'(a - k / T);
            r.mu    = (b > a);
            r.md    = (b < a);
            r.busy  = 1'b1;
        end else if (k < m + D) begin
            r.floor = 2'(b);
            r.door  = 1'b1;
            r.arr   = (k == m);
            r.busy  = 1'b1;
        end else begin
            r.floor = 2'(b);
            r.ready = 1'b1;
        end
        return r;
    endfunction

    task automatic push_trip(input int a, input int b, input int k_lo, input int k_hi);
        for (int k = k_lo; k <= k_hi; k++) exp_q.push_back(rec(a, b, k));
    endtask

    function automatic int trip_len(input int a, input int b);
        return ((b > a) ? b - a : a - b) * T + D;
    endfunction

    // Issue a call from a falling-edge time; it is taken on the next rising edge.
    task automatic issue(input int b);
        req_valid = 1'b1;
        req_floor = 2'(b);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int i;
        i = 0;
        while (exp_q.size() > 0) begin
            obs_t e;
            @(negedge clk);
            e = exp_q.pop_front();
            check_eq($sformatf("%s[%0d]", tag, i), sample(), e);
            i++;
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_floor = 2'd0;
`ifdef EMERG_STOP_EN
        emerg     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset", sample(), 8'b00_000001);

        // 0 -> 3
        push_trip(0, 3, 0, trip_len(0, 3));
        issue(3);
        drain("up03");

        // 3 -> 1 with an ignored call for floor 0 mid-motion
        push_trip(3, 1, 0, trip_len(3, 1));
        issue(1);
        fork
            drain("dn31");
            begin
                repeat (2) @(negedge clk);
                #1 req_valid = 1'b1;
                req_floor = 2'd0;
                repeat (3) @(negedge clk);
                #1 req_valid = 1'b0;
            end
        join

        // 1 -> 2
        push_trip(1, 2, 0, trip_len(1, 2));
        issue(2);
        drain("up12");

        // 2 -> 2 with req_valid held into the first idle cycle: taken again
        push_trip(2, 2, 0, trip_len(2, 2));
        push_trip(2, 2, 0, trip_len(2, 2));
        req_valid = 1'b1;
        req_floor = 2'd2;
        @(posedge clk);
        fork
            drain("same22");
            begin
                repeat (5) @(negedge clk);
                #1 req_valid = 1'b0;
            end
        join

        // 2 -> 0
        push_trip(2, 0, 0, trip_len(2, 0));
        issue(0);
        drain("dn20");

        // 0 -> 3 aborted by reset in cycle 6
        push_trip(0, 3, 0, 5);
        issue(3);
        drain("abort");
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("abort_rst", sample(), 8'b00_000001);

`ifdef EMERG_STOP_EN
        // 0 -> 2 with a 5-cycle freeze while between floors 1 and 2
        push_trip(0, 2, 0, 5);
        repeat (5) exp_q.push_back(obs_t'(8'b01_000010));
        push_trip(0, 2, 6, trip_len(0, 2));
        issue(2);
        fork
            drain("emerg");
            begin
                repeat (6) @(negedge clk);
                #1 emerg = 1'b1;
                repeat (5) @(negedge clk);
                #1 emerg = 1'b0;
            end
        join
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
